audio_adc_capture: RTL and testbench

Receive-side counterpart of the DAC playback path. Deserializes the codec's ADC stream (AUD_ADCDAT framed by AUD_BCLK and AUD_ADCLRCK, left-justified format) into 16-bit left/right samples on the system clock. On demand, it records frame-aligned sample pairs into the audio sample RAM through a simple write port. It sits beside the playback controller and shares the codec serial clocks with the audio interface.

---
 rtl/audio_adc_capture_if.sv | 32 +++
 rtl/audio_adc_capture.sv | 210 +++++++++++++++++++++
 tb/tb_audio_adc_capture.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_adc_capture_if.sv
// Capture-side bus: deserialized sample pair plus the sample-RAM write port.
interface audio_adc_capture_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 19
);
  logic [DATA_WIDTH-1:0]   LDATA_out;
  logic [DATA_WIDTH-1:0]   RDATA_out;
  logic                    sample_valid;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [2*DATA_WIDTH-1:0] wr_data;

  // Capture block drives the bus
  modport master (
    output LDATA_out,
    output RDATA_out,
    output sample_valid,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  // RAM / consumer side
  modport slave (
    input LDATA_out,
    input RDATA_out,
    input sample_valid,
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/audio_adc_capture.sv
// Codec ADC capture: left-justified serial deserializer plus a frame-aligned
// recorder that writes {left,right} pairs into the audio sample RAM.
module audio_adc_capture #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR   = {ADDR_WIDTH{1'b1}}
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                AUD_BCLK,
  input  logic                AUD_ADCLRCK,
  input  logic                AUD_ADCDAT,
  input  logic                record_start,
  input  logic                record_stop,
  output logic                busy,
  output logic                done,
  output logic                short_frame,
  audio_adc_capture_if.master cap
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_REC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // [0],[1] synchronizer stages, [2] delayed copy for edge detection
  logic [2:0]              bclk_sync_q, bclk_sync_d;
  logic [2:0]              lrck_sync_q, lrck_sync_d;
  logic [1:0]              dat_sync_q,  dat_sync_d;

  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    chan_q, chan_d;      // 1 = left, 0 = right
  logic                    framed_q, framed_d;  // seen an LRCK edge since reset
  logic [DATA_WIDTH-1:0]   ldata_q, ldata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    short_frame_q, short_frame_d;

  logic [1:0]              state_q, state_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [2*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    bclk_rise, lrck_rise, lrck_fall, bit_in;
  logic                    commit_r, short_set, short_clr;
  logic [DATA_WIDTH-1:0]   word, padded;

  // Deserializer: sync, edge detect, shift and commit channel words
  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[1:0], AUD_ADCLRCK};
    dat_sync_d  = {dat_sync_q[0], AUD_ADCDAT};
    bclk_rise   = bclk_sync_q[1] & ~bclk_sync_q[2];
    lrck_rise   = lrck_sync_q[1] & ~lrck_sync_q[2];
    lrck_fall   = ~lrck_sync_q[1] & lrck_sync_q[2];
    bit_in      = dat_sync_q[1];

    shift_d   = shift_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    framed_d  = framed_q;
    ldata_d   = ldata_q;
    rdata_d   = rdata_q;
    commit_r  = 1'b0;
    short_set = 1'b0;
    word      = '0;
    padded    = '0;

    // Frame clock edge: flush a partial word MSB-aligned, retarget channel
    if (lrck_rise || lrck_fall) begin
      if (framed_q && (cnt_q != '0) && (cnt_q < CNT_FULL)) begin
        padded    = shift_q << (CNT_FULL - cnt_q);
        short_set = 1'b1;
        if (chan_q) begin
          ldata_d = padded;
        end else begin
          rdata_d  = padded;
          commit_r = 1'b1;
        end
      end
      framed_d = 1'b1;
      chan_d   = lrck_rise;
      cnt_d    = '0;
      shift_d  = '0;
    end

    // Bit clock rise: take one bit until the word is full
    if (framed_d && bclk_rise && (cnt_d < CNT_FULL)) begin
      word    = {shift_d[DATA_WIDTH-2:0], bit_in};
      shift_d = word;
      cnt_d   = cnt_d + CNT_W'(1);
      if (cnt_d == CNT_FULL) begin
        if (chan_d) begin
          ldata_d = word;
        end else begin
          rdata_d  = word;
          commit_r = 1'b1;
        end
      end
    end

    sample_valid_d = commit_r;
  end

  // Recorder FSM: arm on start, write each completed pair while recording
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    short_clr = 1'b0;

    // Address advances the cycle after a write, saturating at the last word
    if (wr_en_q && (wr_addr_q != MAX_ADDR)) begin
      wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (record_start) begin
          state_d   = S_ARM;
          wr_addr_d = '0;
          short_clr = 1'b1;
        end
      end
      S_ARM: begin
        if (record_stop) begin
          state_d = S_DONE;
        end else if (lrck_rise) begin
          state_d = S_REC;
        end
      end
      S_REC: begin
        if (commit_r) begin
          wr_en_d   = 1'b1;
          wr_data_d = {ldata_d, rdata_d};
          if (wr_addr_q == MAX_ADDR) begin
            state_d = S_DONE;
          end
        end
        if (record_stop) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    short_frame_d = (short_clr ? 1'b0 : short_frame_q) | short_set;
    busy_d        = (state_d == S_ARM) || (state_d == S_REC);
    done_d        = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bclk_sync_q    <= '0;
      lrck_sync_q    <= '0;
      dat_sync_q     <= '0;
      shift_q        <= '0;
      cnt_q          <= '0;
      chan_q         <= 1'b0;
      framed_q       <= 1'b0;
      ldata_q        <= '0;
      rdata_q        <= '0;
      sample_valid_q <= 1'b0;
      short_frame_q  <= 1'b0;
      state_q        <= S_IDLE;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      bclk_sync_q    <= bclk_sync_d;
      lrck_sync_q    <= lrck_sync_d;
      dat_sync_q     <= dat_sync_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      chan_q         <= chan_d;
      framed_q       <= framed_d;
      ldata_q        <= ldata_d;
      rdata_q        <= rdata_d;
      sample_valid_q <= sample_valid_d;
      short_frame_q  <= short_frame_d;
      state_q        <= state_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign cap.LDATA_out    = ldata_q;
  assign cap.RDATA_out    = rdata_q;
  assign cap.sample_valid = sample_valid_q;
  assign cap.wr_en        = wr_en_q;
  assign cap.wr_addr      = wr_addr_q;
  assign cap.wr_data      = wr_data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign short_frame      = short_frame_q;

endmodule

// File: tb/tb_audio_adc_capture.sv
// Directed bench for audio_adc_capture: BCLK = 16 Clk, 32 BCLK per half-frame,
// MAX_ADDR overridden to 3.
module tb_audio_adc_capture;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic AUD_BCLK = 1'b0;
  logic AUD_ADCLRCK = 1'b0;
  logic AUD_ADCDAT = 1'b0;
  logic record_start = 1'b0;
  logic record_stop = 1'b0;
  logic busy, done, short_frame;

  audio_adc_capture_if #(.DATA_WIDTH(16), .ADDR_WIDTH(19)) cap ();

  audio_adc_capture #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(19),
    .MAX_ADDR  (19'd3)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .record_start(record_start),
    .record_stop (record_stop),
    .busy        (busy),
    .done        (done),
    .short_frame (short_frame),
    .cap         (cap.master)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int r15_cyc = 0;
  int sv_cyc = 0;
  int sv_n = 0;
  int wr_n = 0;
  int orphan_n = 0;
  logic [18:0] log_addr [0:15];
  logic [31:0] log_data [0:15];

  always @(posedge Clk) cyc <= cyc + 1;

  // Event recorder: sample_valid pulses and RAM writes
  always @(negedge Clk) begin
    if (cap.sample_valid === 1'b1) begin
      sv_n = sv_n + 1;
      sv_cyc = cyc;
    end
    if (cap.wr_en === 1'b1) begin
      if (cap.sample_valid !== 1'b1) orphan_n = orphan_n + 1;
      if (wr_n < 16) begin
        log_addr[4'(wr_n)] = cap.wr_addr;
        log_data[4'(wr_n)] = cap.wr_data;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ldata"}, 32'(cap.LDATA_out), 32'h0);
    chk({tag, "_rdata"}, 32'(cap.RDATA_out), 32'h0);
    chk({tag, "_sv"}, 32'(cap.sample_valid), 32'h0);
    chk({tag, "_wr_en"}, 32'(cap.wr_en), 32'h0);
    chk({tag, "_wr_addr"}, 32'(cap.wr_addr), 32'h0);
    chk({tag, "_wr_data"}, cap.wr_data, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_short"}, 32'(short_frame), 32'h0);
  endtask

  // One half-frame of 32 bit slots; data/LRCK change at BCLK fall.
  // npulse limits BCLK rises; start_at / rst_at inject events at a slot.
  task automatic send_half(input logic lr, input logic [15:0] word, input int npulse,
                           input int start_at, input int rst_at);
    for (int i = 0; i < 32; i++) begin
      @(negedge Clk);
      AUD_BCLK = 1'b0;
      if (i == 0) AUD_ADCLRCK = lr;
      AUD_ADCDAT = (i < 16) ? word[4'(15 - i)] : 1'b0;
      if (i == start_at) begin
        record_start = 1'b1;
        @(negedge Clk);
        record_start = 1'b0;
        repeat (7) @(negedge Clk);
      end else if (i == rst_at) begin
        Reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
      end else begin
        repeat (8) @(negedge Clk);
      end
      if (i < npulse) begin
        AUD_BCLK = 1'b1;
        if (lr == 1'b0 && i == 15) r15_cyc = cyc;
      end
      repeat (8) @(negedge Clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_half(1'b1, l, 32, -1, -1);
    send_half(1'b0, r, 32, -1, -1);
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    record_start = 1'b1;
    @(negedge Clk);
    record_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge Clk);
    record_stop = 1'b1;
    @(negedge Clk);
    record_stop = 1'b0;
  endtask

  int sv0, wr0;

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    Reset = 1'b0;
    repeat (4) @(negedge Clk);

    // Continuous capture while idle
    sv0 = sv_n; wr0 = wr_n;
    send_frame(16'hA5C3, 16'h1234);
    chk("cont_ldata", 32'(cap.LDATA_out), 32'hA5C3);
    chk("cont_rdata", 32'(cap.RDATA_out), 32'h1234);
    chk("cont_sv_cnt1", 32'(sv_n - sv0), 32'd1);
    chk("cont_sv_latency", 32'(sv_cyc - r15_cyc), 32'd3);
    send_frame(16'hA5C3, 16'h1234);
    chk("cont_sv_cnt2", 32'(sv_n - sv0), 32'd2);
    chk("cont_no_write", 32'(wr_n - wr0), 32'd0);

    // Record three frames then stop
    pulse_start();
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_done", 32'(done), 32'd0);
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'hA5C3, 16'h1234);
    send_frame(16'hA5C3, 16'h1234);
    chk("rec3_wr_cnt", 32'(wr_n - wr0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("rec3_addr", 32'(log_addr[4'(k)]), 32'(k));
      chk("rec3_data", log_data[4'(k)], 32'hA5C3_1234);
    end
    pulse_stop();
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_wr_addr", 32'(cap.wr_addr), 32'd3);

    // Start mid-left-word: partial frame must not be written
    wr0 = wr_n; sv0 = sv_n;
    send_half(1'b1, 16'hA5C3, 32, 5, -1);
    chk("midstart_busy", 32'(busy), 32'd1);
    chk("midstart_addr", 32'(cap.wr_addr), 32'd0);
    send_half(1'b0, 16'h1234, 32, -1, -1);
    chk("midstart_sv", 32'(sv_n - sv0), 32'd1);
    chk("midstart_no_wr", 32'(wr_n - wr0), 32'd0);
    send_frame(16'hBEEF, 16'h0F0F);
    chk("first_wr_cnt", 32'(wr_n - wr0), 32'd1);
    chk("first_wr_addr", 32'(log_addr[3]), 32'd0);
    chk("first_wr_data", log_data[3], 32'hBEEF_0F0F);

    // record_start while recording is ignored
    pulse_start();
    chk("rec_start_ign_addr", 32'(cap.wr_addr), 32'd1);
    chk("rec_start_ign_busy", 32'(busy), 32'd1);

    // Fill to MAX_ADDR = 3
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    send_frame(16'h5555, 16'h6666);
    chk("max_wr_cnt", 32'(wr_n - wr0), 32'd4);
    chk("max_addr1", 32'(log_addr[4]), 32'd1);
    chk("max_addr2", 32'(log_addr[5]), 32'd2);
    chk("max_addr3", 32'(log_addr[6]), 32'd3);
    chk("max_data3", log_data[6], 32'h5555_6666);
    chk("max_done", 32'(done), 32'd1);
    chk("max_busy", 32'(busy), 32'd0);
    chk("max_addr_hold", 32'(cap.wr_addr), 32'd3);
    sv0 = sv_n;
    send_frame(16'h7777, 16'h8888);
    chk("post_max_sv", 32'(sv_n - sv0), 32'd1);
    chk("post_max_no_wr", 32'(wr_n - wr0), 32'd4);
    chk("post_max_addr", 32'(cap.wr_addr), 32'd3);
    chk("orphan_writes", 32'(orphan_n), 32'd0);

    // Short right word: 10 ones
    sv0 = sv_n;
    send_half(1'b1, 16'hA5C3, 32, -1, -1);
    send_half(1'b0, 16'hFFFF, 10, -1, -1);
    chk("short_pending", 32'(short_frame), 32'd0);
    send_half(1'b1, 16'h1111, 32, -1, -1);
    chk("short_rdata", 32'(cap.RDATA_out), 32'hFFC0);
    chk("short_flag", 32'(short_frame), 32'd1);
    chk("short_ldata", 32'(cap.LDATA_out), 32'h1111);
    chk("short_sv", 32'(sv_n - sv0), 32'd1);
    pulse_start();
    chk("short_cleared", 32'(short_frame), 32'd0);
    chk("restart_addr", 32'(cap.wr_addr), 32'd0);
    send_half(1'b0, 16'h2222, 32, -1, -1);

    // Reset during a right word while recording
    send_half(1'b1, 16'h1357, 32, -1, -1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    wr0 = wr_n; sv0 = sv_n;
    send_half(1'b0, 16'h2468, 32, -1, 8);
    chk("postrst_rdata", 32'(cap.RDATA_out), 32'h0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_sv", 32'(sv_n - sv0), 32'd0);
    send_frame(16'h1357, 16'h2468);
    chk("postrst_ldata", 32'(cap.LDATA_out), 32'h1357);
    chk("postrst_rdata2", 32'(cap.RDATA_out), 32'h2468);
    chk("postrst_sv2", 32'(sv_n - sv0), 32'd1);
    chk("postrst_no_wr", 32'(wr_n - wr0), 32'd0);
    chk("postrst_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
